// File: rtl/rtype_alu_sequencer_pkg.sv
// Shared definitions for the R-type sequencer: funct codes, ALU select codes,
// FSM states and instruction field positions.
package rtype_alu_sequencer_pkg;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

endpackage

// File: rtl/rtype_alu_sequencer_decoder.sv
// Combinational funct decoder: maps an R-type funct field to the ALU select
// and flags whether the funct is one this datapath implements.
module rtype_funct_decoder
    import rtype_alu_sequencer_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [1:0] o_s,
    output logic       o_legal
);

    always_comb begin
        o_s     = ALU_ADD;
        o_legal = 1'b0;
        case (i_funct)
            FUNCT_ADD: begin o_s = ALU_ADD; o_legal = 1'b1; end
            FUNCT_SUB: begin o_s = ALU_SUB; o_legal = 1'b1; end
            FUNCT_AND: begin o_s = ALU_AND; o_legal = 1'b1; end
            FUNCT_OR:  begin o_s = ALU_OR;  o_legal = 1'b1; end
            default:   begin o_s = ALU_ADD; o_legal = 1'b0; end
        endcase
    end

endmodule

// File: rtl/rtype_alu_sequencer.sv
// Multi-cycle R-type controller: READ -> EXEC -> WB around a shared register
// file and ALU, one instruction every four cycles.
module rtype_alu_sequencer
    import rtype_alu_sequencer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_instr,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [REG_AW-1:0] o_rs_addr,
    output logic [REG_AW-1:0] o_rt_addr,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    output logic [DATA_W-1:0] o_op1,
    output logic [DATA_W-1:0] o_op2,
    output logic [1:0]        o_s,
    input  logic [DATA_W-1:0] i_r_out,
    input  logic              i_zflag,
    output logic [REG_AW-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_wr_en,
    output logic              o_done,
    output logic              o_err,
    output logic              o_zflag
);

    state_t              r_state;
    logic                r_ready;
    logic [REG_AW-1:0]   r_rs;
    logic [REG_AW-1:0]   r_rt;
    logic [REG_AW-1:0]   r_rd;
    logic [1:0]          r_sel;
    logic                r_legal;
    logic [DATA_W-1:0]   r_op1;
    logic [DATA_W-1:0]   r_op2;
    logic [1:0]          r_s;
    logic [REG_AW-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_wr_en;
    logic                r_done;
    logic                r_err;
    logic                r_zflag;

    logic [5:0]          w_funct;
    logic [1:0]          w_sel;
    logic                w_legal;
    logic                w_accept;

    assign w_funct  = i_instr[FUNCT_MSB:FUNCT_LSB];
    assign w_accept = i_valid & r_ready;

    // Decode at accept time so the error pulse can be registered into READ.
    rtype_funct_decoder u_decoder (
        .i_funct (w_funct),
        .o_s     (w_sel),
        .o_legal (w_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ready   <= 1'b1;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_sel     <= ALU_ADD;
            r_legal   <= 1'b0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_s       <= ALU_ADD;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_en   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_zflag   <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rs    <= i_instr[RS_MSB:RS_LSB];
                        r_rt    <= i_instr[RT_MSB:RT_LSB];
                        r_rd    <= i_instr[RD_MSB:RD_LSB];
                        r_sel   <= w_sel;
                        r_legal <= w_legal;
                        r_err   <= ~w_legal;
                        r_ready <= 1'b0;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (r_legal) begin
                        r_op1   <= i_rs_data;
                        r_op2   <= i_rt_data;
                        r_s     <= r_sel;
                        r_state <= ST_EXEC;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                // Result and flag are staged here so they appear during WB.
                ST_EXEC: begin
                    r_wr_addr <= r_rd;
                    r_wr_data <= i_r_out;
                    r_wr_en   <= (r_rd != '0);
                    r_done    <= 1'b1;
                    r_zflag   <= i_zflag;
                    r_state   <= ST_WB;
                end
                ST_WB: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready   = r_ready;
    assign o_rs_addr = r_rs;
    assign o_rt_addr = r_rt;
    assign o_op1     = r_op1;
    assign o_op2     = r_op2;
    assign o_s       = r_s;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_wr_en   = r_wr_en;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_zflag   = r_zflag;

endmodule

// File: tb/tb_rtype_alu_sequencer.sv
// Self-checking bench for rtype_alu_sequencer: a behavioural register file and
// ALU surround the DUT, and a funct-level reference model predicts each result.
module tb_rtype_alu_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] i_instr;
    logic        i_valid;
    logic        o_ready;
    logic [4:0]  o_rs_addr;
    logic [4:0]  o_rt_addr;
    logic [15:0] i_rs_data;
    logic [15:0] i_rt_data;
    logic [15:0] o_op1;
    logic [15:0] o_op2;
    logic [1:0]  o_s;
    logic [15:0] i_r_out;
    logic        i_zflag;
    logic [4:0]  o_wr_addr;
    logic [15:0] o_wr_data;
    logic        o_wr_en;
    logic        o_done;
    logic        o_err;
    logic        o_zflag;

    int errors = 0;
    int checks = 0;

    logic [15:0] envRegs [32];
    logic [15:0] refRegs [32];
    logic        preloadEn;
    logic [4:0]  preloadAddr;
    logic [15:0] preloadData;
    logic        expZ;

    rtype_alu_sequencer #(.DATA_W(16), .REG_AW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_instr   (i_instr),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_rs_addr (o_rs_addr),
        .o_rt_addr (o_rt_addr),
        .i_rs_data (i_rs_data),
        .i_rt_data (i_rt_data),
        .o_op1     (o_op1),
        .o_op2     (o_op2),
        .o_s       (o_s),
        .i_r_out   (i_r_out),
        .i_zflag   (i_zflag),
        .o_wr_addr (o_wr_addr),
        .o_wr_data (o_wr_data),
        .o_wr_en   (o_wr_en),
        .o_done    (o_done),
        .o_err     (o_err),
        .o_zflag   (o_zflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: register file with combinational reads and a 16-bit ALU.
    always @(posedge clk) begin
        if (preloadEn) envRegs[preloadAddr] <= preloadData;
        else if (o_wr_en) envRegs[o_wr_addr] <= o_wr_data;
    end

    assign i_rs_data = envRegs[o_rs_addr];
    assign i_rt_data = envRegs[o_rt_addr];

    always_comb begin
        i_r_out = 16'h0000;
        case (o_s)
            2'b00:   i_r_out = o_op1 + o_op2;
            2'b01:   i_r_out = o_op1 - o_op2;
            2'b10:   i_r_out = o_op1 & o_op2;
            default: i_r_out = o_op1 | o_op2;
        endcase
    end
    assign i_zflag = (i_r_out == 16'h0000);

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic refLegal(input logic [5:0] funct);
        return (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) || (funct == 6'h25);
    endfunction

    function automatic logic [15:0] refCompute(input logic [5:0] funct, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        r = 16'h0000;
        if (funct == 6'h20)      r = 16'((32'(a) + 32'(b)) % 65536);
        else if (funct == 6'h22) r = 16'((32'(a) + 65536 - 32'(b)) % 65536);
        else if (funct == 6'h24) r = a & b;
        else if (funct == 6'h25) r = a | b;
        return r;
    endfunction

    function automatic logic [1:0] refSel(input logic [5:0] funct);
        logic [1:0] s;
        s = 2'd0;
        if (funct == 6'h22)      s = 2'd1;
        else if (funct == 6'h24) s = 2'd2;
        else if (funct == 6'h25) s = 2'd3;
        return s;
    endfunction

    function automatic logic [31:0] mkInstr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'h00, funct};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic valid);
        i_instr = instr;
        i_valid = valid;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic preload(input logic [4:0] addr, input logic [15:0] data);
        preloadEn   = 1'b1;
        preloadAddr = addr;
        preloadData = data;
        tick();
        preloadEn   = 1'b0;
        refRegs[addr] = data;
    endtask

    task automatic runInstr(input string tag, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] funct);
        logic        legal;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] expRes;
        legal  = refLegal(funct);
        a      = refRegs[rs];
        b      = refRegs[rt];
        expRes = refCompute(funct, a, b);

        checkOutput({tag, "_idle_ready"}, 32'(o_ready), 32'd1);
        applyStimulus(mkInstr(rs, rt, rd, funct), 1'b1);
        tick();
        applyStimulus(32'h0, 1'b0);

        checkOutput({tag, "_read_ready"}, 32'(o_ready), 32'd0);
        checkOutput({tag, "_read_err"}, 32'(o_err), 32'(!legal));
        checkOutput({tag, "_read_rs"}, 32'(o_rs_addr), 32'(rs));
        checkOutput({tag, "_read_rt"}, 32'(o_rt_addr), 32'(rt));
        checkOutput({tag, "_read_wren"}, 32'(o_wr_en), 32'd0);
        tick();

        if (!legal) begin
            checkOutput({tag, "_ill_ready"}, 32'(o_ready), 32'd1);
            checkOutput({tag, "_ill_err"}, 32'(o_err), 32'd0);
            checkOutput({tag, "_ill_done"}, 32'(o_done), 32'd0);
            checkOutput({tag, "_ill_wren"}, 32'(o_wr_en), 32'd0);
            checkOutput({tag, "_ill_zflag"}, 32'(o_zflag), 32'(expZ));
            return;
        end

        checkOutput({tag, "_exec_op1"}, 32'(o_op1), 32'(a));
        checkOutput({tag, "_exec_op2"}, 32'(o_op2), 32'(b));
        checkOutput({tag, "_exec_s"}, 32'(o_s), 32'(refSel(funct)));
        checkOutput({tag, "_exec_done"}, 32'(o_done), 32'd0);
        tick();

        checkOutput({tag, "_wb_done"}, 32'(o_done), 32'd1);
        checkOutput({tag, "_wb_wren"}, 32'(o_wr_en), 32'(rd != 5'd0));
        checkOutput({tag, "_wb_addr"}, 32'(o_wr_addr), 32'(rd));
        checkOutput({tag, "_wb_data"}, 32'(o_wr_data), 32'(expRes));
        checkOutput({tag, "_wb_zflag"}, 32'(o_zflag), 32'(expRes == 16'h0000));
        checkOutput({tag, "_wb_ready"}, 32'(o_ready), 32'd0);
        expZ = (expRes == 16'h0000);
        if (rd != 5'd0) refRegs[rd] = expRes;
        tick();

        checkOutput({tag, "_post_ready"}, 32'(o_ready), 32'd1);
        checkOutput({tag, "_post_done"}, 32'(o_done), 32'd0);
        checkOutput({tag, "_post_wren"}, 32'(o_wr_en), 32'd0);
    endtask

    initial begin
        logic [5:0] functTable [6];
        functTable[0] = 6'h20;
        functTable[1] = 6'h22;
        functTable[2] = 6'h24;
        functTable[3] = 6'h25;
        functTable[4] = 6'h2A;
        functTable[5] = 6'h00;

        rst         = 1'b1;
        preloadEn   = 1'b0;
        preloadAddr = 5'd0;
        preloadData = 16'h0000;
        expZ        = 1'b0;
        applyStimulus(32'h0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        checkOutput("reset_ready", 32'(o_ready), 32'd1);
        checkOutput("reset_done", 32'(o_done), 32'd0);
        checkOutput("reset_err", 32'(o_err), 32'd0);
        checkOutput("reset_wren", 32'(o_wr_en), 32'd0);
        checkOutput("reset_zflag", 32'(o_zflag), 32'd0);
        checkOutput("reset_s", 32'(o_s), 32'd0);
        checkOutput("reset_op1", 32'(o_op1), 32'd0);
        checkOutput("reset_wrdata", 32'(o_wr_data), 32'd0);
        checkOutput("reset_rsaddr", 32'(o_rs_addr), 32'd0);

        preload(5'd0, 16'h0000);
        for (int r = 1; r < 32; r++) preload(5'(r), 16'($urandom_range(0, 65535)));

        preload(5'd1, 16'h000A);
        preload(5'd2, 16'h0007);
        preload(5'd4, 16'h1234);
        runInstr("add", 5'd1, 5'd2, 5'd3, 6'h20);
        runInstr("subzero", 5'd4, 5'd4, 5'd5, 6'h22);
        runInstr("and", 5'd1, 5'd2, 5'd11, 6'h24);
        runInstr("illegal", 5'd1, 5'd2, 5'd12, 6'h2A);

        preload(5'd9, 16'hFFFF);
        preload(5'd10, 16'h0001);
        runInstr("rdzero", 5'd9, 5'd10, 5'd0, 6'h20);

        // Reset while the instruction sits in EXEC must discard it.
        applyStimulus(mkInstr(5'd1, 5'd2, 5'd13, 6'h20), 1'b1);
        tick();
        applyStimulus(32'h0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expZ = 1'b0;
        checkOutput("rstexec_ready", 32'(o_ready), 32'd1);
        checkOutput("rstexec_done", 32'(o_done), 32'd0);
        checkOutput("rstexec_wren", 32'(o_wr_en), 32'd0);
        checkOutput("rstexec_err", 32'(o_err), 32'd0);
        checkOutput("rstexec_zflag", 32'(o_zflag), 32'd0);
        tick();
        checkOutput("rstexec_later_done", 32'(o_done), 32'd0);
        checkOutput("rstexec_later_wren", 32'(o_wr_en), 32'd0);
        checkOutput("rstexec_later_ready", 32'(o_ready), 32'd1);

        // Valid held high: accepts land every four cycles.
        preload(5'd6, 16'h00F0);
        preload(5'd7, 16'h000F);
        checkOutput("hold_ready0", 32'(o_ready), 32'd1);
        applyStimulus(mkInstr(5'd6, 5'd7, 5'd8, 6'h25), 1'b1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            checkOutput("hold_done", 32'(o_done), 32'((k % 4) == 3));
            checkOutput("hold_ready", 32'(o_ready), 32'((k % 4) == 0));
            if ((k % 4) == 3) begin
                checkOutput("hold_wrdata", 32'(o_wr_data), 32'h00FF);
                checkOutput("hold_wren", 32'(o_wr_en), 32'd1);
                checkOutput("hold_wraddr", 32'(o_wr_addr), 32'd8);
            end
        end
        applyStimulus(32'h0, 1'b0);
        refRegs[8] = 16'h00FF;
        expZ = 1'b0;
        tick();

        for (int n = 0; n < 16; n++) begin
            runInstr("rand",
                     5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)),
                     functTable[$urandom_range(0, 5)]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
